// File: rtl/intc_pkg.sv
// intc_pkg: config address map and vector-width helper shared by the interrupt controller
package intc_pkg;
  localparam logic [1:0] CFG_MASK = 2'd0;
  localparam logic [1:0] CFG_MODE = 2'd1;
  localparam logic [1:0] CFG_PEND = 2'd2;
  localparam logic [1:0] CFG_ISR  = 2'd3;
  function automatic int vec_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: lowest-set-bit encoder; ports req_i (N) -> valid_o, idx_o (vec_w(N))
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int N = 4,
  localparam int W = vec_w(N)
) (
  input  logic [N-1:0] req_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);
  assign valid_o = |req_i;
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) idx_o = req_i[i] ? W'(i) : idx_o;
  end
endmodule

// File: rtl/mips_intc.sv
// mips_intc: fixed-priority nesting interrupt controller; clk/rst, irq_src, cfg_* bus, int_ack/int_eoi handshake -> irq, int_vec
module mips_intc
  import intc_pkg::*;
#(
  parameter int               N_IRQ       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter logic [N_IRQ-1:0] MODE_RST    = {N_IRQ{1'b1}},
  parameter bit               NEST_EN     = 1'b1,
  localparam int              VW          = vec_w(N_IRQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [N_IRQ-1:0] cfg_wdata,
  output logic [N_IRQ-1:0] cfg_rdata,
  input  logic             int_ack,
  input  logic             int_eoi,
  output logic             irq,
  output logic [VW-1:0]    int_vec
);
  logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q;
  logic [N_IRQ-1:0] hist_q, mask_q, mode_q, pend_q, isr_q;
  logic [N_IRQ-1:0] mask_d, mode_d, pend_d, isr_d;
  logic [N_IRQ-1:0] sync_out, rise, eligible, w1c, ack_oh, eoi_oh;
  logic [VW-1:0]    vec_q, vec_d, best_idx, cur_idx;
  logic             best_v, cur_v, take;
  assign sync_out = sync_q[SYNC_STAGES-1];
  assign eligible = pend_q & mask_q;
  intc_prio_enc #(.N(N_IRQ)) u_best (.req_i(eligible), .valid_o(best_v), .idx_o(best_idx));
  intc_prio_enc #(.N(N_IRQ)) u_cur  (.req_i(isr_q),    .valid_o(cur_v),  .idx_o(cur_idx));
  assign irq     = best_v & (~cur_v | (NEST_EN & (best_idx < cur_idx)));
  assign int_vec = vec_q;
  assign cfg_rdata = cfg_addr == CFG_MASK ? mask_q :
                     cfg_addr == CFG_MODE ? mode_q :
                     cfg_addr == CFG_PEND ? pend_q : isr_q;
  always_comb begin
    take   = int_ack & irq;
    rise   = sync_out & ~hist_q;
    w1c    = (cfg_we && cfg_addr == CFG_PEND) ? cfg_wdata : '0;
    ack_oh = take ? N_IRQ'(1) << best_idx : '0;
    eoi_oh = (int_eoi & cur_v) ? N_IRQ'(1) << cur_idx : '0;
    // edge channels: a fresh rise beats a same-cycle ack/W1C clear; level channels follow the source
    pend_d = (mode_q & ((pend_q & ~ack_oh & ~w1c) | rise)) | (~mode_q & sync_out);
    isr_d  = (isr_q & ~eoi_oh) | ack_oh;
    vec_d  = take ? best_idx : vec_q;
    mask_d = (cfg_we && cfg_addr == CFG_MASK) ? cfg_wdata : mask_q;
    mode_d = (cfg_we && cfg_addr == CFG_MODE) ? cfg_wdata : mode_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= '0;
      mask_q <= '0;
      mode_q <= MODE_RST;
      pend_q <= '0;
      isr_q  <= '0;
      vec_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_src};
      hist_q <= sync_out;
      mask_q <= mask_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
      isr_q  <= isr_d;
      vec_q  <= vec_d;
    end
  end
endmodule
